mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter_if.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle for the 4-requester round-robin arbiter that owns a shared 4:1 mux.
// The master side drives requests and mux data; the slave side returns grant and mux result.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       f;
  logic       preempt;

  modport master (
    output req,
    output d,
    input  grant,
    input  sel,
    input  f,
    input  preempt
  );

  modport slave (
    input  req,
    input  d,
    output grant,
    output sel,
    output f,
    output preempt
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Two-state round-robin arbiter for a shared 4:1 mux with a bounded hold time.
// Every release (voluntary or forced) passes through one idle cycle before the next grant.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] ptr_r;
  logic [1:0] ptr_nxt_s;
  logic [1:0] sel_r;
  logic [1:0] sel_nxt_s;
  logic [3:0] hold_cnt_r;
  logic [3:0] hold_cnt_nxt_s;
  logic [3:0] grant_r;
  logic [3:0] grant_nxt_s;
  logic       f_r;
  logic       f_nxt_s;
  logic       preempt_r;
  logic       preempt_nxt_s;

  // First active request found scanning upward from ptr, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr_v);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr_v;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_v + 2'(i);
      if (!found && req_v[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Next-state, pointer, hold counter and registered-output decode.
  always_comb begin
    state_nxt_s    = state_r;
    ptr_nxt_s      = ptr_r;
    sel_nxt_s      = sel_r;
    hold_cnt_nxt_s = hold_cnt_r;
    preempt_nxt_s  = 1'b0;
    grant_nxt_s    = 4'b0000;
    f_nxt_s        = 1'b0;

    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          state_nxt_s    = OWN;
          sel_nxt_s      = rr_pick(bus.req, ptr_r);
          hold_cnt_nxt_s = 4'd1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN: begin
        if (!bus.req[sel_r]) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = sel_r + 2'd1;
        end else if (hold_cnt_r == MAX_HOLD_C) begin
          // Forced release: owner still wants the mux but its time is up.
          state_nxt_s   = IDLE;
          ptr_nxt_s     = sel_r + 2'd1;
          preempt_nxt_s = 1'b1;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // f follows d through the select that will be live after this edge.
    if (state_nxt_s == OWN) begin
      grant_nxt_s = 4'b0001 << sel_nxt_s;
      f_nxt_s     = bus.d[sel_nxt_s];
    end else begin
      grant_nxt_s = 4'b0000;
      f_nxt_s     = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= 2'd0;
      sel_r      <= 2'd0;
      hold_cnt_r <= 4'd0;
      grant_r    <= 4'b0000;
      f_r        <= 1'b0;
      preempt_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      sel_r      <= sel_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      grant_r    <= grant_nxt_s;
      f_r        <= f_nxt_s;
      preempt_r  <= preempt_nxt_s;
    end
  end

  assign bus.grant   = grant_r;
  assign bus.sel     = sel_r;
  assign bus.f       = f_r;
  assign bus.preempt = preempt_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a cycle-level reference model queues expected
// outputs per issued cycle and an independent monitor pops and compares after each edge.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 8;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       f;
    logic       preempt;
  } exp_t;

  logic clk;
  logic rst;
  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       exp_q[$];
  logic [3:0] grant_log[$];
  logic [3:0] last_grant;
  int         n_tests;
  int         n_fail;

  // Reference model: owner index (-1 = nobody), rotating start pointer, cycles held.
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply one cycle of inputs, advance the model across the coming edge, queue the result.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dd);
    exp_t e;
    int   c;
    rst     = r;
    bus.req = rq;
    bus.d   = dd;
    e.preempt = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      if (rq != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          c = (m_ptr + k) % 4;
          if (m_owner < 0 && rq[c]) m_owner = c;
        end
        m_cnt = 1;
        m_sel = m_owner;
      end
    end else if (!rq[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (m_cnt == MAX_HOLD) begin
      m_ptr     = (m_owner + 1) % 4;
      m_owner   = -1;
      e.preempt = 1'b1;
    end else begin
      m_cnt = m_cnt + 1;
    end
    e.grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.sel   = 2'(m_sel);
    e.f     = (m_owner >= 0) ? dd[m_owner] : 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_log(input string name, input int idx, input logic [3:0] want);
    n_tests++;
    if (idx >= grant_log.size()) begin
      n_fail++;
      $display("FAIL %s[%0d]: only %0d grants seen, required grant=%b", name, idx, grant_log.size(), want);
    end else if (grant_log[idx] !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got grant=%b, required grant=%b", name, idx, grant_log[idx], want);
    end
  endtask

  // Monitor: compare DUT outputs one time unit after every rising edge.
  initial begin
    exp_t e;
    exp_t got;
    last_grant = 4'b0000;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.grant, bus.sel, bus.f, bus.preempt};
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL cycle_check t=%0t: got grant=%b sel=%0d f=%b preempt=%b, required grant=%b sel=%0d f=%b preempt=%b",
                   $time, got.grant, got.sel, got.f, got.preempt, e.grant, e.sel, e.f, e.preempt);
        end
        if (bus.grant != 4'b0000 && last_grant == 4'b0000) grant_log.push_back(bus.grant);
        last_grant = bus.grant;
      end
    end
  end

  initial begin
    logic [3:0] rq_v;
    logic [3:0] order_a[5];
    logic [3:0] order_b[3];
    n_tests = 0;
    n_fail  = 0;
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
    rst     = 1'b1;
    bus.req = 4'b0000;
    bus.d   = 4'b0000;
    order_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    order_b = '{4'b0001, 4'b0100, 4'b0001};

    // Reset state, then two requesters with a release in between.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000);
    repeat (3) step(1'b0, 4'b1010, 4'($urandom));
    repeat (4) step(1'b0, 4'b1000, 4'($urandom));

    // All four requesting, each owner drops after two grant cycles.
    step(1'b1, 4'b0000, 4'b0000);
    grant_log.delete();
    repeat (24) begin
      if (m_owner >= 0 && m_cnt == 2) rq_v = 4'b1111 & ~(4'b0001 << m_owner);
      else rq_v = 4'b1111;
      step(1'b0, rq_v, 4'($urandom));
    end
    for (int i = 0; i < 5; i++) check_log("rotation_order", i, order_a[i]);

    // Single persistent requester hits the hold limit repeatedly.
    step(1'b1, 4'b0000, 4'b0000);
    repeat (25) step(1'b0, 4'b0001, 4'($urandom));

    // Two persistent requesters alternate through preemption.
    step(1'b1, 4'b0000, 4'b0000);
    grant_log.delete();
    repeat (40) step(1'b0, 4'b0101, 4'($urandom));
    for (int i = 0; i < 3; i++) check_log("preempt_order", i, order_b[i]);

    // Mux data path with requester 2 owning, then with nobody owning.
    step(1'b1, 4'b0000, 4'b0000);
    for (int v = 0; v < 16; v++) step(1'b0, 4'b0100, 4'(v));
    for (int v = 0; v < 16; v++) step(1'b0, 4'b0000, 4'(v));

    // Reset while requester 1 owns the mux.
    step(1'b1, 4'b0000, 4'b0000);
    repeat (3) step(1'b0, 4'b0010, 4'($urandom));
    step(1'b1, 4'b0011, 4'($urandom));
    repeat (3) step(1'b0, 4'b0011, 4'($urandom));

    // Random sticky requests with occasional reset.
    rq_v = 4'b0000;
    repeat (600) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) rq_v[b] = ~rq_v[b];
      end
      step(($urandom_range(0, 49) == 0), rq_v, 4'($urandom));
    end
    step(1'b0, 4'b0000, 4'b0000);
    @(negedge clk);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
